// File: rtl/ps2_key_buttons_pkg.sv
// Shared constants and FSM state type for the PS/2 key-to-button conditioner.
// KEY_AUTOREPEAT_EN selects the DELAY/REPEAT states; otherwise a single HELD state.
package ps2_key_pkg;

  localparam logic [7:0] KEY_START_DEF = 8'h75;
  localparam logic [7:0] KEY_LEFT_DEF  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT_DEF = 8'h74;

  // Channel indices double as the sw bit positions.
  localparam int CH_START = 0;
  localparam int CH_RIGHT = 1;
  localparam int CH_LEFT  = 2;
  localparam int NUM_CH   = 3;

`ifdef KEY_AUTOREPEAT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} key_state_e;
`else
  typedef enum logic {ST_IDLE, ST_HELD} key_state_e;
`endif

endpackage

// File: rtl/ps2_key_buttons_if.sv
// Keycode event bus from the PS/2 recognizer: one-cycle keycode_ready strobe
// qualifying keycode, ext and make.
interface ps2_key_buttons_if;
  logic [7:0] keycode;
  logic       ext;
  logic       make;
  logic       keycode_ready;

  modport master (output keycode, ext, make, keycode_ready);
  modport slave  (input  keycode, ext, make, keycode_ready);
endinterface

// File: rtl/ps2_key_buttons_key_channel.sv
// One button channel: key-held flag, press/auto-repeat FSM and registered outputs.
// Auto-repeat exists only when KEY_AUTOREPEAT_EN is defined and ALLOW_REPEAT=1.
module key_channel
  import ps2_key_pkg::*;
#(
  parameter int ALLOW_REPEAT  = 1,
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic make_i,
  input  logic break_i,
  input  logic sw_i,
  output logic held_o,
  output logic strobe_o
);

  if (ALLOW_REPEAT < 0 || ALLOW_REPEAT > 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      CNT_W < 1 || CNT_W > 32 ||
      64'(REPEAT_DELAY - 1) >= (64'd1 << CNT_W) ||
      64'(REPEAT_PERIOD - 1) >= (64'd1 << CNT_W)) begin : g_bad_params
    $error("key_channel: invalid repeat parameters");
  end

  logic       key_held_q, key_held_d;
  logic       level_q, level_d;
  logic       strobe_q, strobe_d;
  key_state_e state_q, state_d;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    key_held_d = key_held_q;
    if (make_i)       key_held_d = 1'b1;
    else if (break_i) key_held_d = 1'b0;
  end

  // The next-cycle level feeds the FSM so the strobe and held output rise together.
  assign level_d = key_held_d | sw_i;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    if (!level_d) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d  = ST_DELAY;
          strobe_d = 1'b1;
          cnt_d    = '0;
        end
        ST_DELAY: begin
          if (ALLOW_REPEAT != 0) begin
            if (cnt_q == DELAY_LAST) begin
              state_d  = ST_REPEAT;
              strobe_d = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_REPEAT: begin
          if (cnt_q == PERIOD_LAST) begin
            strobe_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  always_comb begin
    state_d  = state_q;
    strobe_d = 1'b0;
    if (!level_d) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      state_d  = ST_HELD;
      strobe_d = 1'b1;
    end
  end
`endif

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_held_q <= 1'b0;
      level_q    <= 1'b0;
      strobe_q   <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      key_held_q <= key_held_d;
      level_q    <= level_d;
      strobe_q   <= strobe_d;
      state_q    <= state_d;
    end
  end

  assign held_o   = level_q;
  assign strobe_o = strobe_q;

endmodule

// File: rtl/ps2_key_buttons.sv
// Turns PS/2 make/break events plus board switches into held button levels and
// press/step strobes. KEY_AUTOREPEAT_EN enables left/right auto-repeat.
module ps2_key_buttons
  import ps2_key_pkg::*;
#(
  parameter logic [7:0] KEY_START     = KEY_START_DEF,
  parameter logic [7:0] KEY_LEFT      = KEY_LEFT_DEF,
  parameter logic [7:0] KEY_RIGHT     = KEY_RIGHT_DEF,
  parameter bit         REQUIRE_EXT   = 1'b0,
  parameter int         REPEAT_DELAY  = 12_500_000,
  parameter int         REPEAT_PERIOD = 2_500_000,
  parameter int         CNT_W         = 26
) (
  input  logic                    clk,
  input  logic                    reset,
  ps2_key_buttons_if.slave        key_bus,
  input  logic [NUM_CH-1:0]       sw,
  output logic                    game_start,
  output logic                    right_button,
  output logic                    left_button,
  output logic                    start_pulse,
  output logic                    right_step,
  output logic                    left_step
);

  function automatic logic [7:0] ch_code(input int ch);
    case (ch)
      CH_START: return KEY_START;
      CH_RIGHT: return KEY_RIGHT;
      CH_LEFT:  return KEY_LEFT;
      default:  return 8'h00;
    endcase
  endfunction

  // Two-flop synchronizer per switch bit; switches are asynchronous to clk.
  logic [NUM_CH-1:0] sw_meta_q, sw_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  logic              ev_valid;
  logic [NUM_CH-1:0] held, strobe;

  assign ev_valid = key_bus.keycode_ready && (!REQUIRE_EXT || key_bus.ext);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [7:0] CODE = ch_code(g);
    logic hit;
    assign hit = ev_valid && (key_bus.keycode == CODE);

    key_channel #(
      .ALLOW_REPEAT  ((g == CH_START) ? 0 : 1),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .CNT_W         (CNT_W)
    ) u_key_channel (
      .clk      (clk),
      .reset    (reset),
      .make_i   (hit && key_bus.make),
      .break_i  (hit && !key_bus.make),
      .sw_i     (sw_sync_q[g]),
      .held_o   (held[g]),
      .strobe_o (strobe[g])
    );
  end

  assign game_start   = held[CH_START];
  assign right_button = held[CH_RIGHT];
  assign left_button  = held[CH_LEFT];
  assign start_pulse  = strobe[CH_START];
  assign right_step   = strobe[CH_RIGHT];
  assign left_step    = strobe[CH_LEFT];

endmodule
